// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory image loader.
package imem_loader_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LEN_W      = 16;
    localparam int unsigned CHK_W      = 8;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned BCNT_W     = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_LO,
        ST_HDR_HI,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_e;

    // States in which the byte stream is being consumed.
    function automatic logic is_loading(input state_e s);
        return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

    // States in which a start pulse begins a new load.
    function automatic logic accepts_start(input state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
    endfunction

    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LEN_W-1:0]  idx);
        return base + (ADDR_W'(idx) << 2);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, instruction-memory write port and status of the image loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic                start;
    logic                s_valid;
    logic [BYTE_W-1:0]   s_data;
    logic                s_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WORD_W-1:0]   mem_wdata;
    logic                core_hold;
    logic                busy;
    logic                done;
    logic                error;

    modport master (
        output start, s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata, core_hold, busy, done, error
    );

    modport slave (
        input  start, s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata, core_hold, busy, done, error
    );

endinterface

// File: rtl/imem_loader_byte_to_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; flags the completing byte.
module byte_to_word_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_valid_c,
    output logic [WORD_W-1:0] word_c
);

    localparam int unsigned SHR_W = WORD_W - BYTE_W;

    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [SHR_W-1:0]  shr_q, shr_d;

    // Earlier bytes shift down so the newest byte always lands in the top lane.
    always_comb begin
        cnt_d        = cnt_q;
        shr_d        = shr_q;
        word_valid_c = byte_valid && (cnt_q == BCNT_W'(WORD_BYTES - 1));
        word_c       = {byte_data, shr_q};
        if (clear) begin
            cnt_d = '0;
            shr_d = '0;
        end else if (byte_valid) begin
            cnt_d = cnt_q + BCNT_W'(1);
            shr_d = {byte_data, shr_q[SHR_W-1:BYTE_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            shr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            shr_q <= shr_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory; holds the core in reset
// until a checksum-verified image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       DEPTH     = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 64'd0
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    word_idx_q, word_idx_d;
    logic [CHK_W-1:0]    chk_q, chk_d;
    logic                s_ready_q, s_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                core_hold_q, core_hold_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                xfer_c;
    logic                start_ok_c;
    logic                pack_valid_c;
    logic                word_valid_c;
    logic                last_word_c;
    logic [WORD_W-1:0]   word_c;
    logic [LEN_W-1:0]    hdr_len_c;
    logic [CHK_W-1:0]    chk_sum_c;

    assign xfer_c       = bus.s_valid && s_ready_q;
    assign start_ok_c   = bus.start && accepts_start(state_q);
    assign pack_valid_c = xfer_c && (state_q == ST_DATA);
    assign hdr_len_c    = {bus.s_data, len_q[BYTE_W-1:0]};
    assign chk_sum_c    = chk_q + bus.s_data;
    assign last_word_c  = (word_idx_q == (len_q - LEN_W'(1)));

    byte_to_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear        (start_ok_c),
        .byte_valid   (pack_valid_c),
        .byte_data    (bus.s_data),
        .word_valid_c (word_valid_c),
        .word_c       (word_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the length is range-checked before any word is written.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (bus.start) state_d = ST_HDR_LO;
            end
            ST_HDR_LO: begin
                if (xfer_c) state_d = ST_HDR_HI;
            end
            ST_HDR_HI: begin
                if (xfer_c) begin
                    if (hdr_len_c > LEN_W'(DEPTH))  state_d = ST_ERR;
                    else if (hdr_len_c == '0)       state_d = ST_CHK;
                    else                            state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_valid_c && last_word_c) state_d = ST_CHK;
            end
            ST_CHK: begin
                if (xfer_c) state_d = (chk_sum_c == '0) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; status flags follow the state being entered.
    always_comb begin
        len_d       = len_q;
        chk_d       = chk_q;
        word_idx_d  = word_idx_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = word_valid_c;
        s_ready_d   = is_loading(state_d);
        busy_d      = is_loading(state_d);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERR);
        // Release only once DONE has been held for a cycle; re-hold as soon as it is left.
        core_hold_d = !((state_q == ST_DONE) && (state_d == ST_DONE));

        if (start_ok_c) begin
            len_d      = '0;
            chk_d      = '0;
            word_idx_d = '0;
        end

        if (xfer_c) begin
            unique case (state_q)
                ST_HDR_LO: len_d[BYTE_W-1:0]     = bus.s_data;
                ST_HDR_HI: len_d[LEN_W-1:BYTE_W] = bus.s_data;
                ST_DATA:   chk_d                 = chk_sum_c;
                default:   ;
            endcase
        end

        if (word_valid_c) begin
            mem_wdata_d = word_c;
            mem_addr_d  = word_addr(BASE_ADDR, word_idx_q);
            word_idx_d  = word_idx_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q       <= '0;
            chk_q       <= '0;
            word_idx_q  <= '0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            s_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            core_hold_q <= 1'b1;
        end else begin
            len_q       <= len_d;
            chk_q       <= chk_d;
            word_idx_q  <= word_idx_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            s_ready_q   <= s_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            core_hold_q <= core_hold_d;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.core_hold = core_hold_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames
// checked against a frame-level reference model.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic clk = 1'b0;
    logic reset;

    imem_loader_if bus ();

    imem_loader #(
        .DEPTH     (64),
        .BASE_ADDR (64'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0]  frame_q[$];
    logic [63:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic        exp_done;
    logic        exp_err;

    logic [63:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observed memory writes.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic do_reset();
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        bus.s_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        waited      = 0;
        @(negedge clk);
        while (bus.s_ready !== 1'b1 && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 50) begin
            $display("FAIL send_byte_timeout: byte %02h not accepted, s_ready=%b required 1", b, bus.s_ready);
            n_cmp++;
            n_bad++;
            bus.s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic run_frame(input int gap, input int mid_start);
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        pulse_start();
        foreach (frame_q[i]) begin
            if (i == mid_start) pulse_start();
            send_byte(frame_q[i], gap);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_nominal(input logic [7:0] chk);
        frame_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                    8'h13, 8'h01, 8'hA0, 8'h00, chk};
    endtask

    // Random frame of n words; header-only when n exceeds the memory depth.
    task automatic make_frame(input int n, input bit good);
        logic [7:0] sum;
        logic [7:0] b;
        frame_q.delete();
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        if (n > 64) return;
        sum = 8'h00;
        for (int k = 0; k < 4 * n; k++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            sum = sum + b;
        end
        b = 8'h00 - sum;
        if (!good) b = b ^ 8'($urandom_range(1, 255));
        frame_q.push_back(b);
    endtask

    // Reference: decode the frame by its format rules.
    task automatic model_frame();
        int          n;
        logic [7:0]  sum;
        logic [31:0] w;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n = int'(frame_q[0]) + 256 * int'(frame_q[1]);
        if (n > 64) begin
            exp_err = 1'b1;
            return;
        end
        sum = 8'h00;
        for (int k = 0; k < n; k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
                w   = w | (32'(frame_q[2 + 4 * k + j]) << (8 * j));
                sum = sum + frame_q[2 + 4 * k + j];
            end
            exp_addr_q.push_back(64'(4 * k));
            exp_data_q.push_back(w);
        end
        sum = sum + frame_q[2 + 4 * n];
        if (sum == 8'h00) exp_done = 1'b1;
        else              exp_err  = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.s_ready   !== 1'b0)  begin $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); n_bad++; end
        n_cmp++; if (bus.mem_we    !== 1'b0)  begin $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); n_bad++; end
        n_cmp++; if (bus.mem_addr  !== 64'd0) begin $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); n_bad++; end
        n_cmp++; if (bus.mem_wdata !== 32'd0) begin $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); n_bad++; end
        n_cmp++; if (bus.core_hold !== 1'b1)  begin $display("FAIL rst_core_hold: got %b want 1", bus.core_hold); n_bad++; end
        n_cmp++; if (bus.busy      !== 1'b0)  begin $display("FAIL rst_busy: got %b want 0", bus.busy); n_bad++; end
        n_cmp++; if (bus.done      !== 1'b0)  begin $display("FAIL rst_done: got %b want 0", bus.done); n_bad++; end
        n_cmp++; if (bus.error     !== 1'b0)  begin $display("FAIL rst_error: got %b want 0", bus.error); n_bad++; end
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (bus.s_ready !== 1'b0) begin $display("FAIL idle_s_ready: got %b want 0", bus.s_ready); n_bad++; end
        end
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic test_nominal();
        set_nominal(8'h69);
        run_frame(0, -1);
        n_cmp++; if (wr_addr_q.size() !== 2) begin $display("FAIL nom_wr_count: got %0d want 2", wr_addr_q.size()); n_bad++; end
        if (wr_addr_q.size() == 2) begin
            n_cmp++; if ({wr_addr_q[0], wr_data_q[0]} !== {64'd0, 32'h00500093}) begin
                $display("FAIL nom_wr0: got %h/%h want 0/00500093", wr_addr_q[0], wr_data_q[0]); n_bad++; end
            n_cmp++; if ({wr_addr_q[1], wr_data_q[1]} !== {64'd4, 32'h00A00113}) begin
                $display("FAIL nom_wr1: got %h/%h want 4/00a00113", wr_addr_q[1], wr_data_q[1]); n_bad++; end
            n_cmp++; if (wr_cyc_q[1] - wr_cyc_q[0] !== 4) begin
                $display("FAIL nom_wr_spacing: got %0d want 4", wr_cyc_q[1] - wr_cyc_q[0]); n_bad++; end
        end
        n_cmp++; if (bus.done      !== 1'b1) begin $display("FAIL nom_done: got %b want 1", bus.done); n_bad++; end
        n_cmp++; if (bus.error     !== 1'b0) begin $display("FAIL nom_error: got %b want 0", bus.error); n_bad++; end
        n_cmp++; if (bus.core_hold !== 1'b0) begin $display("FAIL nom_core_hold: got %b want 0", bus.core_hold); n_bad++; end
        n_cmp++; if (bus.busy      !== 1'b0) begin $display("FAIL nom_busy: got %b want 0", bus.busy); n_bad++; end
    endtask

    task automatic test_zero_len();
        frame_q = '{8'h00, 8'h00, 8'h00};
        run_frame(0, -1);
        n_cmp++; if (wr_addr_q.size() !== 0) begin $display("FAIL zero_wr_count: got %0d want 0", wr_addr_q.size()); n_bad++; end
        n_cmp++; if (bus.done      !== 1'b1) begin $display("FAIL zero_done: got %b want 1", bus.done); n_bad++; end
        n_cmp++; if (bus.core_hold !== 1'b0) begin $display("FAIL zero_core_hold: got %b want 0", bus.core_hold); n_bad++; end
    endtask

    task automatic test_oversize();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        pulse_start();
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        n_cmp++; if (bus.error     !== 1'b1) begin $display("FAIL over_error: got %b want 1", bus.error); n_bad++; end
        n_cmp++; if (bus.s_ready   !== 1'b0) begin $display("FAIL over_s_ready: got %b want 0", bus.s_ready); n_bad++; end
        n_cmp++; if (bus.core_hold !== 1'b1) begin $display("FAIL over_core_hold: got %b want 1", bus.core_hold); n_bad++; end
        n_cmp++; if (bus.done      !== 1'b0) begin $display("FAIL over_done: got %b want 0", bus.done); n_bad++; end
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (wr_addr_q.size() !== 0) begin $display("FAIL over_wr_count: got %0d want 0", wr_addr_q.size()); n_bad++; end
    endtask

    // Bad checksum, backpressure gaps, and a start pulse mid-load.
    task automatic test_variants();
        logic [7:0] chk_v[3];
        int         gap_v[3];
        int         mid_v[3];
        chk_v = '{8'h6A, 8'h69, 8'h69};
        gap_v = '{0, 3, 0};
        mid_v = '{-1, -1, 5};
        for (int v = 0; v < 3; v++) begin
            set_nominal(chk_v[v]);
            model_frame();
            run_frame(gap_v[v], mid_v[v]);
            n_cmp++; if (wr_addr_q.size() !== exp_addr_q.size()) begin
                $display("FAIL var%0d_wr_count: got %0d want %0d", v, wr_addr_q.size(), exp_addr_q.size()); n_bad++; end
            for (int k = 0; k < exp_addr_q.size() && k < wr_addr_q.size(); k++) begin
                n_cmp++; if ({wr_addr_q[k], wr_data_q[k]} !== {exp_addr_q[k], exp_data_q[k]}) begin
                    $display("FAIL var%0d_wr%0d: got %h/%h want %h/%h", v, k, wr_addr_q[k], wr_data_q[k], exp_addr_q[k], exp_data_q[k]); n_bad++; end
            end
            n_cmp++; if (bus.done      !== exp_done)  begin $display("FAIL var%0d_done: got %b want %b", v, bus.done, exp_done); n_bad++; end
            n_cmp++; if (bus.error     !== exp_err)   begin $display("FAIL var%0d_error: got %b want %b", v, bus.error, exp_err); n_bad++; end
            n_cmp++; if (bus.core_hold !== !exp_done) begin $display("FAIL var%0d_core_hold: got %b want %b", v, bus.core_hold, !exp_done); n_bad++; end
        end
    endtask

    task automatic test_reset_midload();
        set_nominal(8'h69);
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(frame_q[i], 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++; if (bus.busy      !== 1'b0) begin $display("FAIL mid_busy: got %b want 0", bus.busy); n_bad++; end
        n_cmp++; if (bus.core_hold !== 1'b1) begin $display("FAIL mid_core_hold: got %b want 1", bus.core_hold); n_bad++; end
        n_cmp++; if (bus.s_ready   !== 1'b0) begin $display("FAIL mid_s_ready: got %b want 0", bus.s_ready); n_bad++; end
        n_cmp++; if (bus.mem_we    !== 1'b0) begin $display("FAIL mid_mem_we: got %b want 0", bus.mem_we); n_bad++; end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (wr_addr_q.size() !== 1) begin $display("FAIL mid_wr_count: got %0d want 1", wr_addr_q.size()); n_bad++; end
        if (wr_addr_q.size() >= 1) begin
            n_cmp++; if ({wr_addr_q[0], wr_data_q[0]} !== {64'd0, 32'h00500093}) begin
                $display("FAIL mid_wr0: got %h/%h want 0/00500093", wr_addr_q[0], wr_data_q[0]); n_bad++; end
        end
        model_frame();
        run_frame(0, -1);
        n_cmp++; if (wr_addr_q.size() !== 2) begin $display("FAIL mid_reload_count: got %0d want 2", wr_addr_q.size()); n_bad++; end
        for (int k = 0; k < 2 && k < wr_addr_q.size(); k++) begin
            n_cmp++; if ({wr_addr_q[k], wr_data_q[k]} !== {exp_addr_q[k], exp_data_q[k]}) begin
                $display("FAIL mid_reload_wr%0d: got %h/%h want %h/%h", k, wr_addr_q[k], wr_data_q[k], exp_addr_q[k], exp_data_q[k]); n_bad++; end
        end
        n_cmp++; if (bus.done !== 1'b1) begin $display("FAIL mid_reload_done: got %b want 1", bus.done); n_bad++; end
    endtask

    task automatic test_random();
        int n;
        int gap;
        bit good;
        for (int it = 0; it < 12; it++) begin
            n    = (it == 0) ? 64 : (it == 1) ? 65 : int'($urandom_range(0, 6));
            good = ($urandom_range(0, 3) != 0);
            gap  = int'($urandom_range(0, 2));
            make_frame(n, good);
            model_frame();
            run_frame(gap, -1);
            n_cmp++; if (wr_addr_q.size() !== exp_addr_q.size()) begin
                $display("FAIL rnd%0d_wr_count: got %0d want %0d", it, wr_addr_q.size(), exp_addr_q.size()); n_bad++; end
            for (int k = 0; k < exp_addr_q.size() && k < wr_addr_q.size(); k++) begin
                n_cmp++; if ({wr_addr_q[k], wr_data_q[k]} !== {exp_addr_q[k], exp_data_q[k]}) begin
                    $display("FAIL rnd%0d_wr%0d: got %h/%h want %h/%h", it, k, wr_addr_q[k], wr_data_q[k], exp_addr_q[k], exp_data_q[k]); n_bad++; end
            end
            n_cmp++; if (bus.done      !== exp_done)  begin $display("FAIL rnd%0d_done: got %b want %b", it, bus.done, exp_done); n_bad++; end
            n_cmp++; if (bus.error     !== exp_err)   begin $display("FAIL rnd%0d_error: got %b want %b", it, bus.error, exp_err); n_bad++; end
            n_cmp++; if (bus.core_hold !== !exp_done) begin $display("FAIL rnd%0d_core_hold: got %b want %b", it, bus.core_hold, !exp_done); n_bad++; end
            n_cmp++; if (bus.busy      !== 1'b0)      begin $display("FAIL rnd%0d_busy: got %b want 0", it, bus.busy); n_bad++; end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_len();
        test_oversize();
        test_variants();
        test_reset_midload();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader. It is the write side of the instruction memory that the single-cycle RISC-V core reads.
- Receives a framed image over a valid/ready byte interface, assembles little-endian 32-bit instruction words and writes them sequentially into instruction memory.
- Holds the core in reset (core_hold) until the image is fully loaded and its checksum verified.
- Sits between a host/UART byte source and the Instruction_Memory write port, and drives the core's reset.

Parameters:
DEPTH, 64, instruction memory capacity in 32-bit words
BASE_ADDR, 64'd0, byte address of first written word

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: begin a load (honoured in IDLE, DONE, ERR only)
s_valid  input  1  byte available on s_data
s_data  input  8  stream byte
s_ready  output  1  loader accepts byte this cycle (transfer = s_valid && s_ready)
mem_we  output  1  instruction memory write strobe, one cycle per word
mem_addr  output  64  byte address of write
mem_wdata  output  32  instruction word
core_hold  output  1  drive into core reset; 1 = core held
busy  output  1  load in progress
done  output  1  image loaded and checksum good (sticky until start/reset)
error  output  1  load failed (sticky until start/reset)

Behaviour:
- Clock/reset: single clock clk; reset synchronous, active-high. All state updates on the rising edge.
- Reset values: state=IDLE, s_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, core_hold=1, busy=0, done=0, error=0. Byte counter, word counter, length and checksum all cleared.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (LSB first per word), then one CHK byte. Frame is valid iff (sum of data bytes + CHK) mod 256 == 0. Header bytes are not summed.
- States and transitions:
  - IDLE: start -> HDR_LO (clears done/error/checksum/counters; busy=1, core_hold=1).
  - HDR_LO: on transfer, latch LEN[7:0] -> HDR_HI.
  - HDR_HI: on transfer, latch LEN[15:8]. Then:
    - N > DEPTH -> ERR.
    - N == 0 -> CHK.
    - else -> DATA.
  - DATA: on each transfer, shift the byte into assembly register and add it to the 8-bit checksum. On the 4th byte of a word, register mem_wdata/mem_addr and pulse mem_we the next cycle. mem_addr = BASE_ADDR + 4*word_index, then word_index increments. After word N-1 -> CHK.
  - CHK: on transfer, sum+byte == 0 -> DONE, else ERR.
  - DONE: done=1, busy=0, core_hold=0 (core released the cycle after entering DONE). start -> HDR_LO.
  - ERR: error=1, busy=0, core_hold stays 1. start -> HDR_LO.
- s_ready = 1 in HDR_LO, HDR_HI, DATA, CHK; 0 elsewhere. Gaps in s_valid stall without side effects. Bytes offered in IDLE/DONE/ERR are not accepted.
- Write timing: mem_we asserts exactly one cycle, the cycle after the word's 4th byte is accepted. Back-to-back bytes sustain one word per 4 cycles with no stall.
- start while busy: ignored.
- Simultaneous start and reset: reset wins.
- Reset mid-load: immediate return to IDLE with core_hold=1. Partial memory contents are left as written, with no further writes.
- Word index never exceeds DEPTH-1, because the length check happens before any write.

Decomposition:
- Shared package: loader FSM state enum (IDLE, HDR_LO, HDR_HI, DATA, CHK, DONE, ERR), frame field widths (LEN 16 bits, CHK 8 bits), and word size in bytes (4).
- One natural sub-module: byte_to_word_packer (byte shift register plus 2-bit byte counter, emits word_valid/word). The FSM, checksum and address generation stay in the top.

Test Plan:
- Nominal load:
  - Stimulus: start, then 02 00 93 00 50 00 13 01 A0 00 69 back-to-back.
  - Required: mem_we pulses twice, addr 0 data 0x00500093, then addr 4 data 0x00A00113; done=1, error=0; core_hold falls after DONE.
- Zero-length frame: start, then 00 00 00 -> no mem_we, done=1, core_hold=0.
- Oversize: DEPTH=64, bytes 41 00 -> ERR right after LEN_HI, no mem_we, error=1, core_hold=1, s_ready=0.
- Bad checksum: nominal frame with final byte 6A -> both writes occur, error=1, done=0, core_hold stays 1.
- Backpressure: nominal frame with s_valid low 3 cycles between every byte -> identical writes and result; mem_we never asserts during gaps.
- Reset mid-load: assert reset after the 6th byte of the nominal frame -> next cycle state IDLE, core_hold=1, busy=0, no mem_we. A subsequent start plus full frame loads correctly.
